mips_multicycle_controller: RTL and testbench

//  Moore-FSM control unit for the next-generation multi-cycle MIPS core. It replaces the

---
 rtl/mips_multicycle_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the shared-memory multi-cycle MIPS datapath.
// Memory states stall MEM_LAT cycles; instr_retire pulses on each final cycle.
//
// Ports:
//   clk, rst (sync, active-high)
//   opc, func : IR[31:26], IR[5:0]
//   zero      : ALU zero flag (beq)
//   PCWrite IorD MemRead MemWrite IRWrite MemToReg WDInp RegDst
//   RegWrite ALUSrcA ALUSrcB ALUOperation PCSrc : datapath controls
//   state : current state code, instr_retire : final-cycle pulse
module mips_multicycle_controller #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       WDInp,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       instr_retire
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEXE = 4'd10,
    S_IMMWB  = 4'd11,
    S_JR     = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  state_t           st;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mem_done;

  logic is_jr, is_rt, is_lw, is_mem;
  logic is_beq, is_jmp, is_jal;
  logic is_imm, is_slti;
  logic [2:0] alu_fn;

  logic pc_write, ir_write, reg_write;
  logic mem_write, retire;

  assign mem_done = (cnt == LAST);

  assign is_jr   = (opc == 6'b000000) &&
                   (func == 6'b001000);
  assign is_rt   = (opc == 6'b000000) && !is_jr;
  assign is_lw   = (opc == 6'b100011);
  assign is_mem  = is_lw || (opc == 6'b101011);
  assign is_beq  = (opc == 6'b000100);
  assign is_jal  = (opc == 6'b000011);
  assign is_jmp  = is_jal || (opc == 6'b000010);
  assign is_slti = (opc == 6'b001010);
  assign is_imm  = is_slti || (opc == 6'b001000);

  always_comb begin
    case (func)
      6'b100010: alu_fn = 3'b110;
      6'b100100: alu_fn = 3'b000;
      6'b100101: alu_fn = 3'b001;
      6'b101010: alu_fn = 3'b111;
      default:   alu_fn = 3'b010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_FETCH;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt          = st;
    cnt_nxt      = '0;
    pc_write     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    MemToReg     = 1'b0;
    WDInp        = 1'b0;
    RegDst       = 2'b00;
    reg_write    = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = 3'b010;
    PCSrc        = 2'b00;
    retire       = 1'b0;
    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          is_jr:  nxt = S_JR;
          is_rt:  nxt = S_RTEXE;
          is_mem: nxt = S_MEMADR;
          is_beq: nxt = S_BEQ;
          is_jmp: nxt = S_JUMP;
          is_imm: nxt = S_IMMEXE;
          default: begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_done) nxt = S_MEMWB;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      S_MEMWB: begin
        MemToReg  = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (mem_done) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RTEXE: begin
        ALUSrcA      = 1'b1;
        ALUOperation = alu_fn;
        nxt          = S_RTWB;
      end
      S_RTWB: begin
        RegDst    = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = 1'b1;
        ALUOperation = 3'b110;
        PCSrc        = 2'b01;
        pc_write     = zero;
        retire       = 1'b1;
        nxt          = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
        if (is_jal) begin
          RegDst    = 2'b10;
          WDInp     = 1'b1;
          reg_write = 1'b1;
        end
      end
      S_JR: begin
        PCSrc    = 2'b11;
        pc_write = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_IMMEXE: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = is_slti ? 3'b111 : 3'b010;
        nxt          = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // state-changing strobes are suppressed while reset is held
  assign PCWrite      = pc_write & ~rst;
  assign IRWrite      = ir_write & ~rst;
  assign RegWrite     = reg_write & ~rst;
  assign MemWrite     = mem_write & ~rst;
  assign instr_retire = retire & ~rst;
  assign state        = st;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: two instances (MEM_LAT 1 and 3)
// checked each cycle against an instruction-level sequence model.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       wd_inp;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] st;
    logic       retire;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;

  logic       pcw[2], iord[2], mrd[2], mwr[2];
  logic       irw[2], m2r[2], wdi[2], rgw[2];
  logic       sra[2], ret[2];
  logic [1:0] rdst[2], srb[2], pcs[2];
  logic [2:0] aop[2];
  logic [3:0] stv[2];
  ctl_t       obs[2];

  int total = 0;
  int bad = 0;
  int seq[$];
  logic [63:0] trace;
  int retire_at;
  int ir_at;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gd
    mips_multicycle_controller #(
      .MEM_LAT(g == 0 ? 1 : 3),
      .CNT_W(4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .opc(opc),
      .func(func),
      .zero(zero),
      .PCWrite(pcw[g]),
      .IorD(iord[g]),
      .MemRead(mrd[g]),
      .MemWrite(mwr[g]),
      .IRWrite(irw[g]),
      .MemToReg(m2r[g]),
      .WDInp(wdi[g]),
      .RegDst(rdst[g]),
      .RegWrite(rgw[g]),
      .ALUSrcA(sra[g]),
      .ALUSrcB(srb[g]),
      .ALUOperation(aop[g]),
      .PCSrc(pcs[g]),
      .state(stv[g]),
      .instr_retire(ret[g])
    );
    always_comb obs[g] = {pcw[g], iord[g], mrd[g],
                          mwr[g], irw[g], m2r[g],
                          wdi[g], rdst[g], rgw[g],
                          sra[g], srb[g], aop[g],
                          pcs[g], stv[g], ret[g]};
  end

  task automatic cmp(string nm, ctl_t act, ctl_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cmp_int(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // per-state control values as listed in the control table
  function automatic ctl_t model(int s, logic [5:0] op,
                                 logic [5:0] fn, logic z,
                                 bit fl, bit last);
    ctl_t e = '0;
    e.alu_op = 3'b010;
    e.st = s[3:0];
    e.retire = last;
    case (s)
      0: begin
        e.mem_read = 1; e.src_b = 2'b01;
        e.ir_write = fl; e.pc_write = fl;
      end
      1: e.src_b = 2'b11;
      2: begin e.src_a = 1; e.src_b = 2'b10; end
      3: begin e.iord = 1; e.mem_read = 1; end
      4: begin e.mem_to_reg = 1; e.reg_write = 1; end
      5: begin e.iord = 1; e.mem_write = 1; end
      6: begin
        e.src_a = 1;
        if (fn == 6'b100010) e.alu_op = 3'b110;
        else if (fn == 6'b100100) e.alu_op = 3'b000;
        else if (fn == 6'b100101) e.alu_op = 3'b001;
        else if (fn == 6'b101010) e.alu_op = 3'b111;
      end
      7: begin e.reg_dst = 2'b01; e.reg_write = 1; end
      8: begin
        e.src_a = 1; e.alu_op = 3'b110;
        e.pc_src = 2'b01; e.pc_write = z;
      end
      9: begin
        e.pc_src = 2'b10; e.pc_write = 1;
        if (op == 6'b000011) begin
          e.reg_dst = 2'b10; e.wd_inp = 1; e.reg_write = 1;
        end
      end
      10: begin
        e.src_a = 1; e.src_b = 2'b10;
        if (op == 6'b001010) e.alu_op = 3'b111;
      end
      11: e.reg_write = 1;
      12: begin e.pc_src = 2'b11; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // state walk of one instruction, from first fetch cycle to retire
  task automatic build(int L, logic [5:0] op, logic [5:0] fn);
    seq.delete();
    repeat (L) seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) seq.push_back(12);
        else begin seq.push_back(6); seq.push_back(7); end
      end
      6'b100011: begin
        seq.push_back(2);
        repeat (L) seq.push_back(3);
        seq.push_back(4);
      end
      6'b101011: begin
        seq.push_back(2);
        repeat (L) seq.push_back(5);
      end
      6'b000100: seq.push_back(8);
      6'b000010, 6'b000011: seq.push_back(9);
      6'b001000, 6'b001010: begin
        seq.push_back(10); seq.push_back(11);
      end
      default: ;
    endcase
  endtask

  task automatic run(int g, string nm, logic [5:0] op,
                     logic [5:0] fn, logic z, int len);
    int L;
    ctl_t e;
    L = (g == 0) ? 1 : 3;
    build(L, op, fn);
    cmp_int({nm, "_len"}, seq.size(), len);
    opc = op; func = fn; zero = z;
    trace = '0; retire_at = 0; ir_at = 0;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      e = model(seq[i], op, fn, z, i == L - 1,
                i == seq.size() - 1);
      cmp($sformatf("%s_c%0d", nm, i + 1), obs[g], e);
      trace = {trace[59:0], obs[g].st};
      if (obs[g].retire === 1'b1 && retire_at == 0)
        retire_at = i + 1;
      if (obs[g].ir_write === 1'b1 && ir_at == 0)
        ir_at = i + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(int g);
    ctl_t e;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e = model(0, opc, func, 0, g == 0, 0);
    e.pc_write = 0;
    e.ir_write = 0;
    cmp($sformatf("reset_g%0d", g), obs[g], e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ctl_t e;
    // MEM_LAT = 1
    do_reset(0);
    run(0, "add", 6'b000000, 6'b100000, 0, 4);
    cmp_int("add_trace", trace, 64'h0167);
    cmp_int("add_retire", retire_at, 4);
    run(0, "sub", 6'b000000, 6'b100010, 0, 4);
    run(0, "and", 6'b000000, 6'b100100, 0, 4);
    run(0, "or", 6'b000000, 6'b100101, 0, 4);
    run(0, "slt", 6'b000000, 6'b101010, 0, 4);
    run(0, "rdef", 6'b000000, 6'b000000, 0, 4);
    run(0, "lw1", 6'b100011, 6'b000000, 0, 5);
    run(0, "sw1", 6'b101011, 6'b000000, 0, 4);
    run(0, "beq_t", 6'b000100, 6'b000000, 1, 3);
    run(0, "beq_n", 6'b000100, 6'b000000, 0, 3);
    cmp_int("beq_n_retire", retire_at, 3);
    run(0, "j", 6'b000010, 6'b000000, 0, 3);
    run(0, "jal", 6'b000011, 6'b000000, 0, 3);
    run(0, "jr", 6'b000000, 6'b001000, 0, 3);
    cmp_int("jr_trace", trace, 64'h01c);
    run(0, "addi", 6'b001000, 6'b000000, 0, 4);
    run(0, "slti", 6'b001010, 6'b000000, 0, 4);
    run(0, "nop", 6'b111111, 6'b000000, 0, 2);
    cmp_int("nop_retire", retire_at, 2);
    // MEM_LAT = 3
    do_reset(1);
    run(1, "lw3", 6'b100011, 6'b000000, 0, 9);
    cmp_int("lw3_trace", trace, 64'h000123334);
    cmp_int("lw3_irw", ir_at, 3);
    cmp_int("lw3_retire", retire_at, 9);
    run(1, "sw3", 6'b101011, 6'b000000, 0, 8);
    run(1, "beq3", 6'b000100, 6'b000000, 1, 5);
    run(1, "slti3", 6'b001010, 6'b000000, 0, 6);
    run(1, "nop3", 6'b111111, 6'b000000, 0, 4);
    // reset in the middle of a store access
    opc = 6'b101011; func = 6'd0; zero = 0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    e = model(5, opc, func, 0, 0, 0);
    e.mem_write = 0;
    cmp("rst_memwr", obs[1], e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1, "addi3", 6'b001000, 6'b000000, 0, 6);
    cmp_int("addi3_trace", trace, 64'h0001ab);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
